// File: rtl/seg_display_scheduler.sv
// seg_display_scheduler
//
// Decides what the six 7-segment displays show while a UART is in use.
// There are four kinds of content, listed from highest to lowest priority:
//   ERR  - "Err" plus the error code digit. It is held for HOLD_CYCLES.
//   RX   - "r" plus the received byte in hex. It is held for HOLD_CYCLES.
//   TX   - "t" plus the TX mode letters. It is shown while a frame is in flight.
//   IDLE - the TX mode letters only ("SC" for CS mode, "FF" for FF mode).
// The HEX outputs are registered. New content appears one clock after
// the state update, and is always built from a single state.
//
// Optional build macro:
//   SEG_BLINK_EN - makes the ERR content blink. The half-period is
//                  BLINK_CYCLES. This also adds the BLINK_CYCLES parameter.
//
// Ports:
//   clk        system clock
//   rst        asynchronous reset, active-high
//   cntmodetx  TX mode select (1 = FF, 0 = CS)
//   tx_start   one-cycle pulse, a TX frame begins
//   tx_done    one-cycle pulse, a TX frame ends
//   rx_valid   one-cycle pulse, rx_data is valid
//   rx_data    received byte
//   err        one-cycle pulse, RX framing or parity error
//   err_code   error identifier, valid with err
//   HEX0..HEX5 segment codes, active-low, bit7 = DP, bits 6:0 = g..a

module seg_display_scheduler #(
    parameter int HOLD_CYCLES  = 100_000_000
`ifdef SEG_BLINK_EN
  , parameter int BLINK_CYCLES = 12_500_000
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cntmodetx,
    input  logic       tx_start,
    input  logic       tx_done,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       err,
    input  logic [1:0] err_code,
    output logic [7:0] HEX0,
    output logic [7:0] HEX1,
    output logic [7:0] HEX2,
    output logic [7:0] HEX3,
    output logic [7:0] HEX4,
    output logic [7:0] HEX5
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_S     = 8'h92;
    localparam logic [7:0] SEG_C     = 8'hC6;
    localparam logic [7:0] SEG_F     = 8'h8E;
    localparam logic [7:0] SEG_T     = 8'h87;
    localparam logic [7:0] SEG_R     = 8'hAF;
    localparam logic [7:0] SEG_E     = 8'h86;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TX,
        ST_RX,
        ST_ERR
    } state_t;

    state_t            state_q, state_d;
    logic              tx_busy_q, tx_busy_d;
    logic              rx_pend_q, rx_pend_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [7:0]        rx_byte_q, rx_byte_d;
    logic [1:0]        code_q, code_d;
    logic [5:0][7:0]   hex_q, hex_d;

    // Converts a 4-bit value to its hex digit pattern
    function automatic logic [7:0] hex_digit(input logic [3:0] v);
        logic [7:0] s;
        case (v)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

`ifdef SEG_BLINK_EN
    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [BW-1:0] BLINK_LOAD = BW'(BLINK_CYCLES - 1);

    logic [BW-1:0] blink_q, blink_d;
    logic          blink_off_q, blink_off_d;

    // Blink phase counter. Every err restarts it in the "content" phase.
    // While in ERR it toggles the phase each time it reaches zero.
    always_comb begin
        blink_d     = blink_q;
        blink_off_d = blink_off_q;
        if (err) begin
            blink_d     = BLINK_LOAD;
            blink_off_d = 1'b0;
        end else if (state_q == ST_ERR) begin
            if (blink_q == '0) begin
                blink_d     = BLINK_LOAD;
                blink_off_d = ~blink_off_q;
            end else begin
                blink_d = blink_q - BW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_q     <= '0;
            blink_off_q <= 1'b0;
        end else begin
            blink_q     <= blink_d;
            blink_off_q <= blink_off_d;
        end
    end
`endif

    // Next-state logic.
    // err wins over everything else. An rx_valid that arrives during ERR
    // is saved as pending, so the byte is shown once the error hold ends.
    // IDLE and TX follow the updated busy flag directly.
    always_comb begin
        state_d   = state_q;
        rx_pend_d = rx_pend_q;
        hold_d    = hold_q;
        rx_byte_d = rx_byte_q;
        code_d    = code_q;

        // Setting the flag wins when tx_start and tx_done arrive in the same cycle
        if (tx_start) begin
            tx_busy_d = 1'b1;
        end else if (tx_done) begin
            tx_busy_d = 1'b0;
        end else begin
            tx_busy_d = tx_busy_q;
        end

        if (err) begin
            state_d = ST_ERR;
            code_d  = err_code;
            hold_d  = HOLD_LOAD;
            if (rx_valid) begin
                rx_byte_d = rx_data;
                rx_pend_d = 1'b1;
            end
        end else if (rx_valid && state_q != ST_ERR) begin
            state_d   = ST_RX;
            rx_byte_d = rx_data;
            hold_d    = HOLD_LOAD;
        end else begin
            case (state_q)
                ST_ERR: begin
                    if (rx_valid) begin
                        rx_byte_d = rx_data;
                        rx_pend_d = 1'b1;
                    end
                    if (hold_q == '0) begin
                        if (rx_pend_q || rx_valid) begin
                            state_d   = ST_RX;
                            rx_pend_d = 1'b0;
                            hold_d    = HOLD_LOAD;
                        end else if (tx_busy_d) begin
                            state_d = ST_TX;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        hold_d = hold_q - HW'(1);
                    end
                end
                ST_RX: begin
                    if (hold_q == '0) begin
                        state_d = tx_busy_d ? ST_TX : ST_IDLE;
                    end else begin
                        hold_d = hold_q - HW'(1);
                    end
                end
                default: begin
                    state_d = tx_busy_d ? ST_TX : ST_IDLE;
                end
            endcase
        end
    end

    // Display content is built from the registered state only.
    // This way a frame never combines parts of two different states.
    always_comb begin
        hex_d = {6{SEG_BLANK}};
        case (state_q)
            ST_IDLE, ST_TX: begin
                hex_d[1] = cntmodetx ? SEG_F : SEG_S;
                hex_d[0] = cntmodetx ? SEG_F : SEG_C;
                if (state_q == ST_TX) begin
                    hex_d[5] = SEG_T;
                end
            end
            ST_RX: begin
                hex_d[5] = SEG_R;
                hex_d[1] = hex_digit(rx_byte_q[7:4]);
                hex_d[0] = hex_digit(rx_byte_q[3:0]);
            end
            default: begin
                hex_d[5] = SEG_E;
                hex_d[4] = SEG_R;
                hex_d[3] = SEG_R;
                hex_d[0] = hex_digit({2'b00, code_q});
`ifdef SEG_BLINK_EN
                if (blink_off_q) begin
                    hex_d = {6{SEG_BLANK}};
                end
`endif
            end
        endcase
    end

    // State and display registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            tx_busy_q <= 1'b0;
            rx_pend_q <= 1'b0;
            hold_q    <= '0;
            rx_byte_q <= '0;
            code_q    <= '0;
            hex_q     <= {6{SEG_BLANK}};
        end else begin
            state_q   <= state_d;
            tx_busy_q <= tx_busy_d;
            rx_pend_q <= rx_pend_d;
            hold_q    <= hold_d;
            rx_byte_q <= rx_byte_d;
            code_q    <= code_d;
            hex_q     <= hex_d;
        end
    end

    assign HEX0 = hex_q[0];
    assign HEX1 = hex_q[1];
    assign HEX2 = hex_q[2];
    assign HEX3 = hex_q[3];
    assign HEX4 = hex_q[4];
    assign HEX5 = hex_q[5];

endmodule

// File: tb/tb_seg_display_scheduler.sv
// tb_seg_display_scheduler
//
// Testbench for seg_display_scheduler, built with HOLD_CYCLES = 16 and
// BLINK_CYCLES = 4.
// The reference model does not count cycles down. It remembers the cycle
// at which the current message expires, and it derives the display from
// the kind of message being shown.

module tb_seg_display_scheduler;

    localparam int HOLD  = 16;
    localparam int BLINK = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cntmodetx = 1'b0;
    logic       tx_start = 1'b0;
    logic       tx_done = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       err = 1'b0;
    logic [1:0] err_code = 2'b00;
    logic [7:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic [47:0] dutHex;

    always #5 clk = ~clk;

    seg_display_scheduler #(
        .HOLD_CYCLES (HOLD)
`ifdef SEG_BLINK_EN
      , .BLINK_CYCLES(BLINK)
`endif
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cntmodetx(cntmodetx),
        .tx_start (tx_start),
        .tx_done  (tx_done),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .err      (err),
        .err_code (err_code),
        .HEX0     (HEX0),
        .HEX1     (HEX1),
        .HEX2     (HEX2),
        .HEX3     (HEX3),
        .HEX4     (HEX4),
        .HEX5     (HEX5)
    );

    assign dutHex = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

    int passCount = 0;
    int checkCount = 0;

    // Reference model state.
    // mKind: 0 = no message, 1 = RX, 2 = ERR.
    logic [7:0] segTab [16];
    int         cycle = 0;
    int         mKind = 0;
    int         mEnd = 0;
    int         mErrStart = 0;
    bit         mPend = 0;
    bit         mBusy = 0;
    logic [7:0] mData = 8'h00;
    logic [1:0] mCode = 2'b00;
    logic [47:0] expHex = '1;
    logic        curMode = 1'b0;

    // Counts one comparison and reports it if observed differs from expected
    task automatic checkOutput(input string tag, input logic [47:0] observed,
                               input logic [47:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Builds the expected display for the model state, as sampled at edge m
    function automatic logic [47:0] expectedHex(input int m);
        logic [7:0] h [6];
        for (int i = 0; i < 6; i++) h[i] = 8'hFF;
        if (mKind == 2) begin
            h[5] = 8'h86;
            h[4] = 8'hAF;
            h[3] = 8'hAF;
            h[0] = segTab[{2'b00, mCode}];
`ifdef SEG_BLINK_EN
            if ((((m - mErrStart - 1) / BLINK) % 2) == 1) begin
                for (int i = 0; i < 6; i++) h[i] = 8'hFF;
            end
`endif
        end else if (mKind == 1) begin
            h[5] = 8'hAF;
            h[1] = segTab[mData[7:4]];
            h[0] = segTab[mData[3:0]];
        end else begin
            if (mBusy) h[5] = 8'h87;
            h[1] = cntmodetx ? 8'h8E : 8'h92;
            h[0] = cntmodetx ? 8'h8E : 8'hC6;
        end
        return {h[5], h[4], h[3], h[2], h[1], h[0]};
    endfunction

    // Advances the model by one clock edge, using the inputs sampled at that edge
    task automatic stepModel();
        if (rst) begin
            mKind  = 0;
            mPend  = 0;
            mBusy  = 0;
            mData  = 8'h00;
            mCode  = 2'b00;
            expHex = '1;
        end else begin
            expHex = expectedHex(cycle);
            if (tx_start) mBusy = 1;
            else if (tx_done) mBusy = 0;
            if (err) begin
                mKind     = 2;
                mCode     = err_code;
                mEnd      = cycle + HOLD;
                mErrStart = cycle;
                if (rx_valid) begin
                    mData = rx_data;
                    mPend = 1;
                end
            end else if (rx_valid) begin
                mData = rx_data;
                if (mKind == 2) begin
                    mPend = 1;
                end else begin
                    mKind = 1;
                    mEnd  = cycle + HOLD;
                end
            end
            if (mKind != 0 && cycle == mEnd) begin
                if (mKind == 2 && mPend) begin
                    mKind = 1;
                    mPend = 0;
                    mEnd  = cycle + HOLD;
                end else begin
                    mKind = 0;
                end
            end
        end
        cycle++;
    endtask

    // Drives one cycle of inputs at the falling edge, then checks the
    // display just after the next rising edge
    task automatic applyStimulus(input logic r, input logic m, input logic ts,
                                 input logic td, input logic rv, input logic [7:0] rd,
                                 input logic e, input logic [1:0] ec);
        logic rose;
        @(negedge clk);
        rose      = r && !rst;
        rst       = r;
        cntmodetx = m;
        tx_start  = ts;
        tx_done   = td;
        rx_valid  = rv;
        rx_data   = rd;
        err       = e;
        err_code  = ec;
        if (rose) begin
            #1;
            checkOutput($sformatf("async_reset@%0d", cycle), dutHex, '1);
        end
        @(posedge clk);
        stepModel();
        #1;
        checkOutput($sformatf("hex@%0d", cycle), dutHex, expHex);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, curMode, 0, 0, 0, 8'h00, 0, 2'b00);
    endtask

    initial begin
        segTab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                   8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        #1 rst = 1'b1;
        #1 checkOutput("reset_state", dutHex, '1);
        applyStimulus(1, 0, 0, 0, 0, 8'h00, 0, 2'b00);
        applyStimulus(1, 0, 0, 0, 0, 8'h00, 0, 2'b00);

        // Release reset in CS mode, then switch to FF mode
        idle(3);
        curMode = 1'b1;
        idle(3);
        curMode = 1'b0;

        // Show a received byte, then retrigger it partway through the hold
        applyStimulus(0, curMode, 0, 0, 1, 8'h3A, 0, 2'b00);
        idle(9);
        applyStimulus(0, curMode, 0, 0, 1, 8'h3A, 0, 2'b00);
        idle(20);

        // TX busy marker, including start and done in the same cycle
        applyStimulus(0, curMode, 1, 0, 0, 8'h00, 0, 2'b00);
        idle(3);
        applyStimulus(0, curMode, 0, 1, 0, 8'h00, 0, 2'b00);
        idle(2);
        applyStimulus(0, curMode, 1, 1, 0, 8'h00, 0, 2'b00);
        idle(3);
        applyStimulus(0, curMode, 0, 1, 0, 8'h00, 0, 2'b00);
        idle(2);

        // An error during RX, with a byte arriving while the error is shown
        applyStimulus(0, curMode, 0, 0, 1, 8'h55, 0, 2'b00);
        idle(2);
        applyStimulus(0, curMode, 0, 0, 0, 8'h00, 1, 2'b10);
        idle(3);
        applyStimulus(0, curMode, 0, 0, 1, 8'h7F, 0, 2'b00);
        idle(40);

        // Error and byte in the same cycle, then an error retrigger
        applyStimulus(0, curMode, 0, 0, 1, 8'hC4, 1, 2'b01);
        idle(6);
        applyStimulus(0, curMode, 0, 0, 0, 8'h00, 1, 2'b11);
        idle(40);

        // Reset asserted in the middle of an error while TX is busy
        applyStimulus(0, curMode, 1, 0, 0, 8'h00, 0, 2'b00);
        applyStimulus(0, curMode, 0, 0, 0, 8'h00, 1, 2'b01);
        idle(5);
        applyStimulus(1, curMode, 0, 0, 0, 8'h00, 0, 2'b00);
        idle(5);

        // Randomized traffic
        for (int i = 0; i < 2500; i++) begin
            logic r, ts, td, rv, e;
            if ($urandom_range(49) == 0) curMode = ~curMode;
            r  = ($urandom_range(299) == 0);
            ts = ($urandom_range(19) == 0);
            td = ($urandom_range(19) == 0);
            rv = ($urandom_range(24) == 0);
            e  = ($urandom_range(59) == 0);
            if (r) begin
                applyStimulus(1, curMode, 0, 0, 0, 8'h00, 0, 2'b00);
            end else begin
                applyStimulus(0, curMode, ts, td, rv, 8'($urandom), e, 2'($urandom));
            end
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
